uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
Second-generation UART transmitter. It serialises parallel words of parametrised width with a runtime-programmable baud divider, optional even/odd parity, and 1 or 2 stop bits. A one-entry holding register with a valid/ready handshake lets frames go out back-to-back with no idle gap. It drops in where the single-word transmitter sits, between the host data path and the TX pad.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
DIV_WIDTH, 16, width of the baud divider input.

Ports:
CLK  input  1  system clock, rising edge
RST_ASYN  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  word to transmit, LSB sent first
Data_Valid  input  1  P_DATA/config valid
Data_Ready  output  1  holding register empty; word accepted on the edge where Data_Valid & Data_Ready
PAR_EN  input  1  parity bit included in frame
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  0 = one stop bit, 1 = two stop bits
BAUD_DIV  input  DIV_WIDTH  each bit lasts BAUD_DIV+1 CLK cycles
TX_OUT  output  1  serial line, idle high, registered
busy  output  1  high while any frame bit (start..last stop) is driven
frame_done  output  1  one-cycle pulse in the last cycle of the last stop bit

Behaviour:
- Reset (RST_ASYN=0, acts immediately):
  - TX_OUT=1, busy=0, frame_done=0, Data_Ready=0 while asserted.
  - Holding register cleared; FSM to IDLE; baud counter and bit counter cleared.
  - Data_Ready=1 from the first edge after release.
- Accept:
  - On edge E with Data_Valid & Data_Ready, the holding register captures P_DATA, PAR_EN, PAR_TYP and STOP2.
  - Parity is computed at this point: even = ^P_DATA; odd = ~^P_DATA.
  - Data_Ready=0 after E.
  - Data_Valid while Data_Ready=0 is ignored; the source must hold its values.
- Frame load:
  - When the FSM is in IDLE, or is in the last cycle of the last stop bit, and the holding register is full, the next edge does all of the following:
    - copies the holding register to the shift register;
    - latches BAUD_DIV;
    - empties the holding register, so Data_Ready=1;
    - enters START.
  - Minimum latency from idle: accept at E, TX_OUT=0 from E+1.
- FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP1 -> (STOP2 if STOP2) -> IDLE, or -> START if the holding register is full.
- Bit timing:
  - A baud counter counts 0..latched BAUD_DIV; a state advances when the counter reaches latched BAUD_DIV.
  - DATA uses a bit counter 0..DATA_WIDTH-1, shifting out LSB first.
  - BAUD_DIV=0 gives one cycle per bit.
- Line values: TX_OUT is 0 in START, data bit in DATA, parity in PARITY, 1 in STOP1/STOP2/IDLE.
- Frame length: (2 + DATA_WIDTH + PAR_EN + STOP2)*(BAUD_DIV+1) cycles.
- busy=1 exactly while the FSM is not in IDLE.
- Back-to-back: no idle cycle between the last stop bit and the next start bit.
- Config stability: changes to BAUD_DIV/PAR_EN/PAR_TYP/STOP2 during a frame do not affect the frame in flight.
- Simultaneous accept and load on the same edge (holding empty, IDLE) is impossible by construction; an accept can occur in the same cycle as frame_done only if the holding register was empty.
- Reset mid-frame aborts the frame immediately: TX_OUT=1, no frame_done.

Test Plan:
1. Reset with Data_Valid=1 -> during reset TX_OUT=1, busy=0, Data_Ready=0; after release Data_Ready=1; no frame starts until the first accepting edge.
2. DATA_WIDTH=8, BAUD_DIV=3, PAR_EN=1, PAR_TYP=0, STOP2=0, P_DATA=0xA5 -> TX_OUT: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit 4 cycles. 44 cycles of busy; frame_done in cycle 44.
3. PAR_TYP=1, STOP2=1, BAUD_DIV=0, P_DATA=0x00 -> TX_OUT 0, eight 0s, parity 1, 1, 1; 12 cycles of busy.
4. Back-to-back 0x55 then 0x0F, Data_Valid held, BAUD_DIV=1, PAR_EN=0 -> Data_Ready rises at START of frame 1 and the second word is accepted. The start bit of frame 2 follows the last stop cycle of frame 1 directly; busy stays high for 40 cycles.
5. Change BAUD_DIV from 3 to 7 and PAR_EN from 0 to 1 mid-DATA -> current frame keeps 4-cycle bits and no parity; the next frame uses 8-cycle bits with parity.
6. Assert RST_ASYN mid-DATA with the holding register full -> TX_OUT=1 and busy=0 immediately; no frame_done; after release the held word is lost and Data_Ready=1.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: one-entry holding register feeding a start/data/parity/stop
// serialiser with a runtime baud divider; frames can go out back-to-back with no idle gap.
module uart_tx_buffered #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_ASYN,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [DIV_WIDTH-1:0]  BAUD_DIV,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  par_bit;
    logic                  par_en;
    logic                  stop2;
  } word_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  word_t                frame_q, frame_d;
  word_t                hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 rdy_q, rdy_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 last_baud, last_stop, load, accept;

  // State and datapath registers; line parks high while reset is held.
  always_ff @(posedge CLK or negedge RST_ASYN) begin
    if (!RST_ASYN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rdy_q       <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rdy_q       <= rdy_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, holding register and look-ahead of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    last_baud = (cnt_q == div_q);
    last_stop = last_baud && (((state_q == S_STOP1) && !frame_q.stop2) || (state_q == S_STOP2));
    load      = hold_full_q && ((state_q == S_IDLE) || last_stop);
    accept    = Data_Valid && rdy_q;

    if (state_q != S_IDLE) begin
      cnt_d = last_baud ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      S_START: begin
        if (last_baud) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (last_baud) begin
          frame_d.data = frame_q.data >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = frame_q.par_en ? S_PARITY : S_STOP1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: if (last_baud) state_d = S_STOP1;
      S_STOP1:  if (last_baud) state_d = frame_q.stop2 ? S_STOP2 : S_IDLE;
      S_STOP2:  if (last_baud) state_d = S_IDLE;
      default: ;
    endcase

    // A full holding register overrides the return to IDLE, giving gapless frames.
    if (load) begin
      state_d     = S_START;
      cnt_d       = '0;
      bit_d       = '0;
      frame_d     = hold_q;
      div_d       = BAUD_DIV;
      hold_full_d = 1'b0;
    end

    if (accept) begin
      hold_d.data    = P_DATA;
      hold_d.par_bit = PAR_TYP ? ~^P_DATA : ^P_DATA;
      hold_d.par_en  = PAR_EN;
      hold_d.stop2   = STOP2;
      hold_full_d    = 1'b1;
    end

    rdy_d  = !hold_full_d;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = frame_d.data[0];
      S_PARITY: tx_d = frame_d.par_bit;
      default:  tx_d = 1'b1;
    endcase
    done_d = (cnt_d == div_d) &&
             (((state_d == S_STOP1) && !frame_d.stop2) || (state_d == S_STOP2));
  end

  assign Data_Ready = rdy_q;
  assign TX_OUT     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: the driver pushes the expected line waveform of each
// accepted word, and a monitor checks every busy cycle against it.
module tb_uart_tx_buffered;

  logic        CLK;
  logic        RST_ASYN;
  logic [7:0]  P_DATA;
  logic        Data_Valid;
  logic        Data_Ready;
  logic        PAR_EN;
  logic        PAR_TYP;
  logic        STOP2;
  logic [15:0] BAUD_DIV;
  logic        TX_OUT;
  logic        busy;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          div;
  } frame_t;

  frame_t sb[$];

  uart_tx_buffered #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .CLK(CLK), .RST_ASYN(RST_ASYN), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .Data_Ready(Data_Ready), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .BAUD_DIV(BAUD_DIV), .TX_OUT(TX_OUT), .busy(busy), .frame_done(frame_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Line waveform of one frame, built bit by bit from the framing rules.
  function automatic frame_t model(input logic [7:0] d, input logic pen, input logic ptyp,
                                   input logic s2, input int div);
    frame_t f;
    int n;
    f.bits = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    n = 9;
    if (pen) begin
      f.bits[n] = (($countones(d) % 2) == 1) ^ ptyp;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (s2) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = n;
    f.div   = div;
    return f;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge CLK);
    while (!Data_Ready && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (!Data_Ready) chk("ready_timeout", 32'(Data_Ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                      input logic s2, input int div);
    wait_ready();
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    STOP2      = s2;
    BAUD_DIV   = 16'(div);
    Data_Valid = 1'b1;
    sb.push_back(model(d, pen, ptyp, s2, div));
    @(posedge CLK);
    #1 Data_Valid = 1'b0;
  endtask

  task automatic measure_busy(input string name, input int exp);
    int n = 0;
    int len = 0;
    @(negedge CLK);
    while (!busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    while (busy && len < 1000) begin
      len++;
      @(negedge CLK);
    end
    chk(name, 32'(len), 32'(exp));
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while ((sb.size() != 0 || busy) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: each rise of busy opens a frame, checked cycle by cycle against the next entry.
  initial begin : monitor
    frame_t e;
    int     total;
    bit     abort;
    forever begin
      @(negedge CLK);
      if (RST_ASYN && busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 32'(busy), 32'd0);
        end else begin
          e     = sb.pop_front();
          total = e.nbits * (e.div + 1);
          abort = 1'b0;
          for (int i = 0; i < total && !abort; i++) begin
            if (i != 0) @(negedge CLK);
            if (!RST_ASYN) begin
              abort = 1'b1;
            end else begin
              chk("tx_bit", 32'(TX_OUT), 32'(e.bits[i / (e.div + 1)]));
              chk("busy_in_frame", 32'(busy), 32'd1);
              chk("frame_done", 32'(frame_done), 32'(i == total - 1));
            end
          end
        end
      end else if (RST_ASYN) begin
        chk("idle_line", {30'd0, TX_OUT, frame_done}, 32'h2);
      end
    end
  end

  initial begin : stim
    RST_ASYN   = 1'b0;
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b1;
    STOP2      = 1'b0;
    BAUD_DIV   = 16'd2;
    Data_Valid = 1'b1;

    // Reset with a valid word pending: nothing moves until the first accepting edge.
    sb.push_back(model(8'h3C, 1'b1, 1'b1, 1'b0, 2));
    #23;
    chk("rst_tx", 32'(TX_OUT), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(Data_Ready), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge CLK);
    RST_ASYN = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", 32'(Data_Ready), 32'd1);
    chk("idle_after_rst", 32'(busy), 32'd0);
    @(posedge CLK);
    #1 Data_Valid = 1'b0;
    wait_idle();

    // 0xA5, even parity, one stop, 4-cycle bits.
    fork
      measure_busy("busy_len_a5", 44);
      send(8'hA5, 1'b1, 1'b0, 1'b0, 3);
    join
    wait_idle();

    // 0x00, odd parity, two stops, 1-cycle bits.
    fork
      measure_busy("busy_len_00", 12);
      send(8'h00, 1'b1, 1'b1, 1'b1, 0);
    join
    wait_idle();

    // Back-to-back words: no idle gap, Data_Ready reopens as frame 1 starts.
    fork
      measure_busy("busy_len_b2b", 40);
      begin
        send(8'h55, 1'b0, 1'b0, 1'b0, 1);
        @(negedge CLK);
        chk("ready_low_held", 32'(Data_Ready), 32'd0);
        @(negedge CLK);
        chk("ready_at_start", {30'd0, Data_Ready, busy}, 32'h3);
        send(8'h0F, 1'b0, 1'b0, 1'b0, 1);
      end
    join
    wait_idle();

    // Config change mid-DATA leaves the in-flight frame alone.
    send(8'hC3, 1'b0, 1'b0, 1'b0, 3);
    repeat (14) @(posedge CLK);
    send(8'h6B, 1'b1, 1'b0, 1'b0, 7);
    wait_idle();

    // Reset mid-DATA with a word held: abort at once, held word lost.
    send(8'h96, 1'b0, 1'b0, 1'b0, 3);
    send(8'h71, 1'b1, 1'b1, 1'b0, 3);
    repeat (10) @(posedge CLK);
    #2 RST_ASYN = 1'b0;
    #1;
    chk("abort_tx", 32'(TX_OUT), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(Data_Ready), 32'd0);
    sb.delete();
    repeat (3) @(negedge CLK);
    RST_ASYN = 1'b1;
    @(negedge CLK);
    chk("ready_after_abort", 32'(Data_Ready), 32'd1);
    repeat (30) @(negedge CLK);
    chk("held_word_lost", 32'(busy), 32'd0);

    // Randomised words, configs and gaps.
    for (int k = 0; k < 24; k++) begin
      send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
